// File: rtl/demux32_stream_1to2.sv
// demux32_stream_1to2: registered 1-to-2 stream demux with a one-entry holding slot per port
module demux32_stream_1to2 #(
  parameter int WIDTH = 32,
  parameter int CW = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] outA_data,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [WIDTH-1:0] outB_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [CW-1:0]    countA,
  output logic [CW-1:0]    countB
);
  logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [CW-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             drain_a, drain_b, load_a, load_b;
  // slot next-state: a drained slot may reload in the same cycle, so a streaming port never bubbles
  always_comb begin
    drain_a   = a_valid_q & outA_ready;
    drain_b   = b_valid_q & outB_ready;
    in_ready  = !Rst & (sel ? (!a_valid_q | outA_ready) : (!b_valid_q | outB_ready));
    load_a    = in_valid & in_ready & sel;
    load_b    = in_valid & in_ready & !sel;
    a_valid_d = load_a | (a_valid_q & !drain_a);
    b_valid_d = load_b | (b_valid_q & !drain_b);
    a_data_d  = load_a ? in_data : a_data_q;
    b_data_d  = load_b ? in_data : b_data_q;
    a_cnt_d   = drain_a ? a_cnt_q + CW'(1) : a_cnt_q;
    b_cnt_d   = drain_b ? b_cnt_q + CW'(1) : b_cnt_q;
  end
  // state registers; reset discards held words without counting them
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end
  assign outA_data  = a_data_q;
  assign outA_valid = a_valid_q;
  assign outB_data  = b_data_q;
  assign outB_valid = b_valid_q;
  assign countA     = a_cnt_q;
  assign countB     = b_cnt_q;
endmodule

// File: tb/tb_demux32_stream_1to2.sv
// tb_demux32_stream_1to2: directed vectors for the stream demux, including a 4-bit counter instance
module tb_demux32_stream_1to2;
  logic        Clk = 0, Rst = 1, in_valid = 0, sel = 0, outA_ready = 0, outB_ready = 0;
  logic [31:0] in_data = '0;
  logic        in_ready, outA_valid, outB_valid, w_in_ready, w_a_valid, w_b_valid;
  logic [31:0] outA_data, outB_data, w_a_data, w_b_data;
  logic [15:0] countA, countB;
  logic [3:0]  w_countA, w_countB;
  int          n_vec = 0, n_bad = 0;

  always #5 Clk = ~Clk;

  demux32_stream_1to2 dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .sel(sel), .in_ready(in_ready),
    .outA_data(outA_data), .outA_valid(outA_valid), .outA_ready(outA_ready),
    .outB_data(outB_data), .outB_valid(outB_valid), .outB_ready(outB_ready),
    .countA(countA), .countB(countB)
  );

  demux32_stream_1to2 #(.CW(4)) dut_w (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .sel(sel), .in_ready(w_in_ready),
    .outA_data(w_a_data), .outA_valid(w_a_valid), .outA_ready(outA_ready),
    .outB_data(w_b_data), .outB_valid(w_b_valid), .outB_ready(outB_ready),
    .countA(w_countA), .countB(w_countB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    in_valid = 1; sel = 1;
    step();
    chk("rst_in_ready", 32'(in_ready), 0);
    step();
    chk("rst_a_valid", 32'(outA_valid), 0);
    chk("rst_b_valid", 32'(outB_valid), 0);
    chk("rst_a_data", outA_data, 0);
    chk("rst_b_data", outB_data, 0);
    chk("rst_cnt_a", 32'(countA), 0);
    chk("rst_cnt_b", 32'(countB), 0);
    Rst = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    in_valid = 0;
    step();
    // single word to A
    sel = 1; in_data = 32'hDEADBEEF; in_valid = 1; outA_ready = 1;
    #1;
    chk("a_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    chk("a_valid", 32'(outA_valid), 1);
    chk("a_data", outA_data, 32'hDEADBEEF);
    chk("a_b_idle", 32'(outB_valid), 0);
    chk("a_cnt_pre", 32'(countA), 0);
    step();
    chk("a_cnt", 32'(countA), 1);
    chk("a_drained", 32'(outA_valid), 0);
    // stalled B, A independent, no-bubble reload
    outA_ready = 0; outB_ready = 0;
    sel = 0; in_data = 32'h11111111; in_valid = 1;
    step();
    in_data = 32'h22222222;
    #1;
    chk("b_full_in_ready", 32'(in_ready), 0);
    chk("b_hold_data", outB_data, 32'h11111111);
    sel = 1; in_data = 32'h33333333;
    #1;
    chk("a_open_in_ready", 32'(in_ready), 1);
    step();
    chk("a_load_33", outA_data, 32'h33333333);
    chk("b_still_11", outB_data, 32'h11111111);
    sel = 0; in_data = 32'h22222222;
    #1;
    chk("b_stall_in_ready", 32'(in_ready), 0);
    outB_ready = 1;
    #1;
    chk("b_drain_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 0;
    chk("b_nobubble_valid", 32'(outB_valid), 1);
    chk("b_nobubble_data", outB_data, 32'h22222222);
    chk("b_cnt1", 32'(countB), 1);
    chk("a_held", 32'(outA_valid), 1);
    outA_ready = 1;
    step();
    chk("cnt_a2", 32'(countA), 2);
    chk("cnt_b2", 32'(countB), 2);
    chk("both_empty", 32'({outA_valid, outB_valid}), 0);
    // alternating stream from a clean reset
    Rst = 1;
    step();
    Rst = 0;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + 32'(i); sel = (i % 2 == 0); in_valid = 1;
      #1;
      chk($sformatf("stream_rdy%0d", i), 32'(in_ready), 1);
      step();
      chk($sformatf("stream_data%0d", i), (i % 2 == 0) ? outA_data : outB_data, 32'h100 + 32'(i));
    end
    in_valid = 0;
    step();
    chk("stream_cnt_a", 32'(countA), 4);
    chk("stream_cnt_b", 32'(countB), 4);
    // 17 words to A: 4-bit counter wraps to 1
    Rst = 1;
    step();
    Rst = 0;
    sel = 1; in_valid = 1;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'hA000 + 32'(i);
      step();
    end
    in_valid = 0;
    step();
    chk("wrap_cnt_a_w", 32'(w_countA), 1);
    chk("wrap_cnt_b_w", 32'(w_countB), 0);
    chk("wrap_cnt_a_full", 32'(countA), 17);
    chk("wrap_last_a", w_a_data, 32'hA010);
    // reset with both slots full and stalled
    outA_ready = 0; outB_ready = 0;
    sel = 1; in_data = 32'hAAAA0001; in_valid = 1;
    step();
    sel = 0; in_data = 32'hBBBB0002;
    step();
    in_valid = 0;
    chk("full_a", 32'(outA_valid), 1);
    chk("full_b", 32'(outB_valid), 1);
    Rst = 1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    step();
    chk("rst_mid_valids", 32'({outA_valid, outB_valid}), 0);
    chk("rst_mid_cnt_a", 32'(countA), 0);
    chk("rst_mid_cnt_b", 32'(countB), 0);
    chk("rst_mid_data", outA_data | outB_data, 0);
    Rst = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
